os_rx_checker: RTL and testbench

OS_RX_CHECKER -- requirements
Module: os_rx_checker

---
 rtl/pcie_os_pkg.sv | 29 ++
 rtl/os_lane_classifier.sv | 69 ++++++
 rtl/os_rx_checker.sv | 140 ++++++++++++++
 tb/tb_os_rx_checker.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pcie_os_pkg.sv
// Shared ordered-set definitions for the receive path.
// Holds the symbol constants used to recognise ordered sets on the wire and
// the osType encoding reported by the checker.
package pcie_os_pkg;

   localparam logic [7:0] SYM_BC = 8'hBC;  // COM (8b/10b K28.5)
   localparam logic [7:0] SYM_7C = 8'h7C;  // IDL (EIOS body)
   localparam logic [7:0] SYM_1C = 8'h1C;  // SKP symbol
   localparam logic [7:0] SYM_4A = 8'h4A;  // TS1 identifier
   localparam logic [7:0] SYM_45 = 8'h45;  // TS2 identifier
   localparam logic [7:0] SYM_1E = 8'h1E;  // 128b/130b TS1 first symbol
   localparam logic [7:0] SYM_2D = 8'h2D;  // 128b/130b TS2 first symbol
   localparam logic [7:0] SYM_66 = 8'h66;  // 128b/130b EIOS symbol
   localparam logic [7:0] SYM_AA = 8'hAA;  // 128b/130b SKP symbol
   localparam logic [7:0] SYM_00 = 8'h00;  // EIEOS low symbol
   localparam logic [7:0] SYM_FF = 8'hFF;  // EIEOS high symbol

   typedef enum logic [2:0] {
      OS_NONE    = 3'd0,
      OS_TS1     = 3'd1,
      OS_TS2     = 3'd2,
      OS_EIOS    = 3'd3,
      OS_SKP     = 3'd4,
      OS_EIEOS   = 3'd5,
      OS_MIXED   = 3'd6,
      OS_INVALID = 3'd7
   } os_type_e;

endpackage

// File: rtl/os_lane_classifier.sv
// Combinational classifier for one lane slot of an ordered-set block.
// Ports:
//   slot      : 16 symbols of one lane, symbol k at [8k +: 8]
//   gen       : link generation, 1-2 use 8b/10b rules, 3-5 use 128b/130b rules
//   lane_type : ordered-set type recognised on this lane (INVALID if none)
module os_lane_classifier
   import pcie_os_pkg::*;
(
   input  logic [127:0] slot,
   input  logic [2:0]   gen,
   output os_type_e     lane_type
);

   logic [7:0] sym [16];
   logic       ts1_tail;
   logic       ts2_tail;
   logic       all_66;
   logic       aa_head;
   logic       eieos_pat;

   always_comb begin
      ts1_tail  = 1'b1;
      ts2_tail  = 1'b1;
      all_66    = 1'b1;
      aa_head   = 1'b1;
      eieos_pat = 1'b1;
      for (int k = 0; k < 16; k++) begin
         sym[k] = slot[8*k +: 8];
      end
      for (int k = 6; k < 16; k++) begin
         ts1_tail = ts1_tail & (sym[k] == SYM_4A);
         ts2_tail = ts2_tail & (sym[k] == SYM_45);
      end
      for (int k = 0; k < 16; k++) begin
         all_66 = all_66 & (sym[k] == SYM_66);
         // EIEOS alternates 00/FF, starting with 00 on symbol 0
         eieos_pat = eieos_pat & (sym[k] == ((k % 2 == 1) ? SYM_FF : SYM_00));
      end
      for (int k = 0; k < 12; k++) begin
         aa_head = aa_head & (sym[k] == SYM_AA);
      end

      lane_type = OS_INVALID;
      if (gen < 3'd3) begin
         if (sym[0] == SYM_BC) begin
            if (ts1_tail)
               lane_type = OS_TS1;
            else if (ts2_tail)
               lane_type = OS_TS2;
            else if (sym[1] == SYM_7C && sym[2] == SYM_7C && sym[3] == SYM_7C)
               lane_type = OS_EIOS;
            else if (sym[1] == SYM_1C && sym[2] == SYM_1C && sym[3] == SYM_1C)
               lane_type = OS_SKP;
         end
      end else begin
         if (sym[0] == SYM_1E)
            lane_type = OS_TS1;
         else if (sym[0] == SYM_2D)
            lane_type = OS_TS2;
         else if (all_66)
            lane_type = OS_EIOS;
         else if (aa_head)
            lane_type = OS_SKP;
         else if (eieos_pat)
            lane_type = OS_EIEOS;
      end
   end

endmodule

// File: rtl/os_rx_checker.sv
// Receive-side ordered-set checker.
// Classifies every active lane of a lane-ordered OS block, merges the lane
// results into one osType, captures the lane-0 TS fields and lane numbers,
// and counts consecutive identical TS1/TS2 blocks for the LTSSM.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   valid, outOs          : one OS block per valid, lane L symbol k at [128L+8k +: 8]
//   numberOfDetectedLanes : active lanes (1/2/4/8/16); higher lanes are ignored
//   gen                   : link generation 1..5
//   clearCount            : clears the consecutive counter and stored TS copy
//   osValid               : one-cycle strobe, outputs below were updated
//   osType                : merged type (NONE/TS1/TS2/EIOS/SKP/EIEOS/MIXED/INVALID)
//   linkNumber, tsFields  : lane-0 symbol 1 and symbols 3..6
//   laneNumbers           : symbol 2 of each active lane, lane L at [8L +: 8]
//   consecutiveCount      : consecutive identical TS count, saturating
//   ts1Seen8, ts2Seen8    : count >= 8 for TS1 / TS2 respectively
module os_rx_checker
   import pcie_os_pkg::*;
#(
   parameter int MAX_LANES = 16,
   parameter int COUNT_SAT = 16
)
(
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     valid,
   input  logic [128*MAX_LANES-1:0] outOs,
   input  logic [4:0]               numberOfDetectedLanes,
   input  logic [2:0]               gen,
   input  logic                     clearCount,
   output logic                     osValid,
   output logic [2:0]               osType,
   output logic [7:0]               linkNumber,
   output logic [8*MAX_LANES-1:0]   laneNumbers,
   output logic [31:0]              tsFields,
   output logic [4:0]               consecutiveCount,
   output logic                     ts1Seen8,
   output logic                     ts2Seen8
);

   function automatic logic [4:0] sat_inc(input logic [4:0] c);
      if (32'(c) >= COUNT_SAT)
         return 5'(COUNT_SAT);
      return c + 5'd1;
   endfunction

   os_type_e                 lane_type [MAX_LANES];
   os_type_e                 blk_type_p0;
   logic [8*MAX_LANES-1:0]   lane_nums_p0;
   logic [111:0]             cmp_p0;
   logic                     identical_p0;
   int                       n_active;
   logic                     any_invalid;
   logic                     disagree;

   // Stored copy of the last counted TS: type, gen and lane-0 symbols 1,3..15
   logic                     store_vld;
   os_type_e                 store_type;
   logic [2:0]               store_gen;
   logic [111:0]             store_cmp;

   for (genvar L = 0; L < MAX_LANES; L++) begin : g_lane
      os_lane_classifier u_cls (
         .slot      (outOs[128*L +: 128]),
         .gen       (gen),
         .lane_type (lane_type[L])
      );
   end

   // Stage p0: merge lane types, gather fields, compare with stored copy
   always_comb begin
      n_active     = int'(numberOfDetectedLanes);
      any_invalid  = 1'b0;
      disagree     = 1'b0;
      lane_nums_p0 = '0;
      // Lane 0 always participates so a block always has a defined type
      for (int L = 0; L < MAX_LANES; L++) begin
         if (L == 0 || L < n_active) begin
            if (lane_type[L] == OS_INVALID)
               any_invalid = 1'b1;
            if (lane_type[L] != lane_type[0])
               disagree = 1'b1;
            lane_nums_p0[8*L +: 8] = outOs[128*L + 16 +: 8];
         end
      end
      if (any_invalid)
         blk_type_p0 = OS_INVALID;
      else if (disagree)
         blk_type_p0 = OS_MIXED;
      else
         blk_type_p0 = lane_type[0];

      // Lane number (symbol 2) is deliberately left out of the comparison
      cmp_p0       = {outOs[127:24], outOs[15:8]};
      identical_p0 = store_vld && (store_type == blk_type_p0) &&
                     (store_gen == gen) && (store_cmp == cmp_p0);
   end

   // Stage p1: registered outputs and consecutive-TS tracking
   always_ff @(posedge clk) begin
      if (reset) begin
         osValid          <= 1'b0;
         osType           <= OS_NONE;
         linkNumber       <= '0;
         laneNumbers      <= '0;
         tsFields         <= '0;
         consecutiveCount <= '0;
         store_vld        <= 1'b0;
         store_type       <= OS_NONE;
      end else begin
         osValid <= valid;
         if (valid) begin
            osType      <= blk_type_p0;
            linkNumber  <= outOs[15:8];
            laneNumbers <= lane_nums_p0;
            tsFields    <= outOs[55:24];
         end
         if (clearCount) begin
            consecutiveCount <= '0;
            store_vld        <= 1'b0;
         end else if (valid) begin
            case (blk_type_p0)
               OS_TS1, OS_TS2: begin
                  consecutiveCount <= identical_p0 ? sat_inc(consecutiveCount) : 5'd1;
                  store_vld        <= 1'b1;
                  store_type       <= blk_type_p0;
                  store_gen        <= gen;
                  store_cmp        <= cmp_p0;
               end
               OS_SKP: ;  // SKP is transparent to the TS sequence
               default: consecutiveCount <= '0;
            endcase
         end
      end
   end

   assign ts1Seen8 = (consecutiveCount >= 5'd8) && (store_type == OS_TS1);
   assign ts2Seen8 = (consecutiveCount >= 5'd8) && (store_type == OS_TS2);

endmodule

// File: tb/tb_os_rx_checker.sv
// Bench for os_rx_checker: directed ordered-set sequences followed by random
// blocks, every output compared each cycle with a behavioural model.
module tb_os_rx_checker;

   localparam int K_TS1 = 1, K_TS2 = 2, K_EIOS = 3, K_SKP = 4, K_EIEOS = 5, K_JUNK = 7;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          valid = 1'b0;
   logic [2047:0] outOs = '0;
   logic [4:0]    numberOfDetectedLanes = 5'd1;
   logic [2:0]    gen = 3'd1;
   logic          clearCount = 1'b0;
   logic          osValid;
   logic [2:0]    osType;
   logic [7:0]    linkNumber;
   logic [127:0]  laneNumbers;
   logic [31:0]   tsFields;
   logic [4:0]    consecutiveCount;
   logic          ts1Seen8;
   logic          ts2Seen8;

   always #5 clk = ~clk;

   os_rx_checker #(.MAX_LANES(16), .COUNT_SAT(16)) dut (
      .clk                   (clk),
      .reset                 (reset),
      .valid                 (valid),
      .outOs                 (outOs),
      .numberOfDetectedLanes (numberOfDetectedLanes),
      .gen                   (gen),
      .clearCount            (clearCount),
      .osValid               (osValid),
      .osType                (osType),
      .linkNumber            (linkNumber),
      .laneNumbers           (laneNumbers),
      .tsFields              (tsFields),
      .consecutiveCount      (consecutiveCount),
      .ts1Seen8              (ts1Seen8),
      .ts2Seen8              (ts2Seen8)
   );

   int vectors = 0;
   int miscompares = 0;

   // Block under construction: blk[lane][symbol]
   logic [7:0] blk [16][16];

   // Reference model state
   logic         m_osValid;
   int           m_type;
   logic [7:0]   m_link;
   logic [127:0] m_lanes;
   logic [31:0]  m_fields;
   int           m_cnt;
   bit           s_vld;
   int           s_type;
   int           s_gen;
   logic [7:0]   s_syms [16];

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int lane_kind(input int L, input int g);
      bit t1 = 1, t2 = 1, e66 = 1, aa = 1, ei = 1;
      for (int k = 6; k < 16; k++) begin
         if (blk[L][k] != 8'h4A) t1 = 0;
         if (blk[L][k] != 8'h45) t2 = 0;
      end
      for (int k = 0; k < 16; k++) begin
         if (blk[L][k] != 8'h66) e66 = 0;
         if (blk[L][k] != ((k % 2) ? 8'hFF : 8'h00)) ei = 0;
         if (k < 12 && blk[L][k] != 8'hAA) aa = 0;
      end
      if (g <= 2) begin
         if (blk[L][0] != 8'hBC) return K_JUNK;
         if (t1) return K_TS1;
         if (t2) return K_TS2;
         if (blk[L][1] == 8'h7C && blk[L][2] == 8'h7C && blk[L][3] == 8'h7C) return K_EIOS;
         if (blk[L][1] == 8'h1C && blk[L][2] == 8'h1C && blk[L][3] == 8'h1C) return K_SKP;
         return K_JUNK;
      end
      if (blk[L][0] == 8'h1E) return K_TS1;
      if (blk[L][0] == 8'h2D) return K_TS2;
      if (e66) return K_EIOS;
      if (aa) return K_SKP;
      if (ei) return K_EIEOS;
      return K_JUNK;
   endfunction

   task automatic model_step(input bit rst, input bit v, input bit clr, input int nl, input int g);
      int  t;
      bit  same;
      if (rst) begin
         m_osValid = 0; m_type = 0; m_link = 0; m_lanes = 0; m_fields = 0;
         m_cnt = 0; s_vld = 0; s_type = 0;
         return;
      end
      m_osValid = v;
      t = lane_kind(0, g);
      if (v) begin
         bit inv = 0, mix = 0;
         m_lanes = 0;
         for (int L = 0; L < nl; L++) begin
            if (lane_kind(L, g) == K_JUNK) inv = 1;
            if (lane_kind(L, g) != t) mix = 1;
            m_lanes[8*L +: 8] = blk[L][2];
         end
         t = inv ? 7 : (mix ? 6 : t);
         m_type   = t;
         m_link   = blk[0][1];
         m_fields = {blk[0][6], blk[0][5], blk[0][4], blk[0][3]};
      end
      if (clr) begin
         m_cnt = 0;
         s_vld = 0;
      end else if (v) begin
         if (t == K_TS1 || t == K_TS2) begin
            same = s_vld && s_type == t && s_gen == g;
            for (int k = 1; k < 16; k++)
               if (k != 2 && blk[0][k] != s_syms[k]) same = 0;
            m_cnt = same ? ((m_cnt + 1 > 16) ? 16 : m_cnt + 1) : 1;
            s_vld = 1; s_type = t; s_gen = g;
            for (int k = 0; k < 16; k++) s_syms[k] = blk[0][k];
         end else if (t != K_SKP) begin
            m_cnt = 0;
         end
      end
   endtask

   task automatic fill_lane(input int L, input int kind, input int g, input logic [7:0] link,
                            input logic [7:0] nfts);
      for (int k = 0; k < 16; k++) blk[L][k] = 8'($urandom);
      case (kind)
         K_TS1, K_TS2: begin
            if (g <= 2) blk[L][0] = 8'hBC;
            else blk[L][0] = (kind == K_TS1) ? 8'h1E : 8'h2D;
            blk[L][1] = link; blk[L][2] = 8'(L); blk[L][3] = nfts;
            blk[L][4] = 8'h06; blk[L][5] = 8'h00;
            for (int k = 6; k < 16; k++)
               blk[L][k] = (g <= 2 && kind == K_TS2) ? 8'h45 : 8'h4A;
         end
         K_EIOS:
            for (int k = 0; k < 16; k++)
               blk[L][k] = (g <= 2) ? ((k == 0) ? 8'hBC : 8'h7C) : 8'h66;
         K_SKP:
            if (g <= 2) begin
               for (int k = 0; k < 16; k++) blk[L][k] = (k == 0) ? 8'hBC : 8'h1C;
            end else begin
               for (int k = 0; k < 12; k++) blk[L][k] = 8'hAA;
               blk[L][12] = 8'hE1;
            end
         K_EIEOS:
            for (int k = 0; k < 16; k++) blk[L][k] = (k % 2) ? 8'hFF : 8'h00;
         default: blk[L][0] = 8'h5A;
      endcase
   endtask

   task automatic fill_all(input int nl, input int kind, input int g, input logic [7:0] link,
                           input logic [7:0] nfts);
      for (int L = 0; L < 16; L++) fill_lane(L, (L < nl) ? kind : K_JUNK, g, link, nfts);
   endtask

   task automatic compare_all();
      check("osValid", 128'(osValid), 128'(m_osValid));
      check("osType", 128'(osType), 128'(m_type));
      check("linkNumber", 128'(linkNumber), 128'(m_link));
      check("laneNumbers", laneNumbers, m_lanes);
      check("tsFields", 128'(tsFields), 128'(m_fields));
      check("count", 128'(consecutiveCount), 128'(m_cnt));
      check("ts1Seen8", 128'(ts1Seen8), 128'(m_cnt >= 8 && s_type == K_TS1));
      check("ts2Seen8", 128'(ts2Seen8), 128'(m_cnt >= 8 && s_type == K_TS2));
   endtask

   task automatic drive(input bit rst, input bit v, input bit clr, input int nl, input int g);
      reset = rst; valid = v; clearCount = clr;
      numberOfDetectedLanes = 5'(nl); gen = 3'(g);
      for (int L = 0; L < 16; L++)
         for (int k = 0; k < 16; k++) outOs[128*L + 8*k +: 8] = blk[L][k];
      model_step(rst, v, clr, nl, g);
      @(posedge clk);
      #1;
      compare_all();
   endtask

   initial begin
      fill_all(1, K_JUNK, 1, 8'h00, 8'h00);
      drive(1, 1, 0, 4, 1);
      drive(1, 0, 0, 4, 1);
      check("rst_type", 128'(osType), 128'd0);

      // Gen1 x4: eight identical TS1
      for (int i = 1; i <= 8; i++) begin
         fill_all(4, K_TS1, 1, 8'h00, 8'h10);
         drive(0, 1, 0, 4, 1);
         check("g1_ts1_cnt", 128'(consecutiveCount), 128'(i));
      end
      check("g1_ts1_seen8", 128'(ts1Seen8), 128'd1);
      check("g1_lanes", 128'(laneNumbers[31:0]), 128'h03020100);
      drive(0, 0, 0, 4, 1);

      // Gen3 x2: TS2 x5, SKP, TS2 x3
      for (int i = 0; i < 9; i++) begin
         fill_all(2, (i == 5) ? K_SKP : K_TS2, 3, 8'h07, 8'h10);
         drive(0, 1, 0, 2, 3);
         if (i == 5) check("skp_hold", 128'(consecutiveCount), 128'd5);
      end
      check("g3_ts2_cnt", 128'(consecutiveCount), 128'd8);
      check("g3_ts2_seen8", 128'(ts2Seen8), 128'd1);

      // Gen1 x4: lane 2 TS2 among TS1, junk above lane 3
      fill_all(4, K_TS1, 1, 8'h00, 8'h10);
      fill_lane(2, K_TS2, 1, 8'h00, 8'h10);
      drive(0, 1, 0, 4, 1);
      check("mixed_type", 128'(osType), 128'd6);
      check("mixed_cnt", 128'(consecutiveCount), 128'd0);

      // N_FTS change restarts the count
      for (int i = 0; i < 3; i++) begin
         fill_all(4, K_TS1, 1, 8'h00, (i < 2) ? 8'h10 : 8'h20);
         drive(0, 1, 0, 4, 1);
      end
      check("nfts_cnt", 128'(consecutiveCount), 128'd1);
      check("nfts_field", 128'(tsFields[7:0]), 128'h20);

      // clearCount with valid at count 7
      for (int i = 0; i < 6; i++) drive(0, 1, 0, 4, 1);
      check("pre_clr_cnt", 128'(consecutiveCount), 128'd7);
      drive(0, 1, 1, 4, 1);
      check("clr_cnt", 128'(consecutiveCount), 128'd0);
      drive(0, 1, 0, 4, 1);
      check("post_clr_cnt", 128'(consecutiveCount), 128'd1);

      // Reset mid-sequence at count 5, then Gen3 x1 EIOS
      for (int i = 0; i < 4; i++) drive(0, 1, 0, 4, 1);
      check("pre_rst_cnt", 128'(consecutiveCount), 128'd5);
      drive(1, 1, 0, 4, 1);
      check("rst_all", {osValid, osType, linkNumber, tsFields, consecutiveCount, ts1Seen8, ts2Seen8}
                       | 128'(laneNumbers != 0), 128'd0);
      fill_all(1, K_EIOS, 3, 8'h00, 8'h00);
      drive(0, 1, 0, 1, 3);
      check("g3_eios", 128'(osType), 128'd3);

      // Random blocks with frequent repeats so counts build up
      begin
         int g = 1, nl = 4, kind = K_TS1, kinds[6] = '{1, 2, 3, 4, 5, 7};
         logic [7:0] link = 8'h00, nfts = 8'h10;
         for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 9) < 3) begin
               if ($urandom_range(0, 3) == 0) g = $urandom_range(1, 5);
               nl   = 1 << $urandom_range(0, 4);
               kind = kinds[$urandom_range(0, 5)];
               link = ($urandom_range(0, 1) == 1) ? 8'h05 : 8'h00;
               nfts = ($urandom_range(0, 1) == 1) ? 8'h20 : 8'h10;
            end
            fill_all(nl, kind, g, link, nfts);
            if ($urandom_range(0, 9) == 0)
               fill_lane($urandom_range(0, nl - 1), kinds[$urandom_range(0, 5)], g, link, nfts);
            drive($urandom_range(0, 99) == 0, $urandom_range(0, 9) < 8,
                  $urandom_range(0, 29) == 0, nl, g);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
